// File: rtl/axi_mem_pkg.sv
// Shared constants for the 3-channel AXI memory slave: FSM state encodings and response codes.
package axi_mem_pkg;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/axi_mem_rd_port.sv
// One AXI read channel (AR/R) of the frame-buffer slave. It fetches words from the shared
// array through rd_idx_o/rd_word_i, a combinational lookup owned by the top.
module axi_mem_rd_port
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [7:0]            arlen_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [ADDR_WIDTH-1:0] rd_idx_o,
    input  logic [DATA_WIDTH-1:0] rd_word_i
);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // While a beat is presented, the word to fetch next is the one after it.
    assign rd_idx_o = rvalid_q ? (addr_q + ADDR_WIDTH'(1)) : addr_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        case (state_q)
            R_IDLE: begin
                if (arvalid_i && arready_q) begin
                    addr_d    = araddr_i;
                    len_d     = arlen_i;
                    cnt_d     = '0;
                    arready_d = 1'b0;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_word_i;
                    rlast_d  = (cnt_q == len_q);
                end else if (rready_i) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = R_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        cnt_d   = cnt_q + 8'd1;
                        rdata_d = rd_word_i;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: begin
                state_d   = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
        if (!rst_ni) begin
            state_q   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/axi_mem_slave_3ch.sv
// Word-indexed AXI memory slave used as a frame buffer: one INCR write port ending on wlast,
// and two independent read ports sharing the same array.
module axi_mem_slave_3ch
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int MEM_SIZE    = 921600,
    parameter int INIT_OPTION = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] araddr_2,
    input  logic [7:0]            arlen_2,
    input  logic                  arvalid_2,
    output logic                  arready_2,
    output logic [DATA_WIDTH-1:0] rdata_2,
    output logic                  rlast_2,
    output logic                  rvalid_2,
    input  logic                  rready_2
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    // One-shot power-on fill; deliberately independent of rst_n so reset keeps the frame.
    logic                  init_done_q = 1'b0;

    logic [1:0]            wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we;

    logic [ADDR_WIDTH-1:0] rd_idx_1, rd_idx_2;
    logic [DATA_WIDTH-1:0] rd_word_1, rd_word_2;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
        return idx < ADDR_WIDTH'(MEM_SIZE);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] idx);
        if (in_range(idx)) begin
            return mem_q[idx[IDX_W-1:0]];
        end
        return '0;
    endfunction

    always_comb begin
        wstate_d  = wstate_q;
        waddr_d   = waddr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        mem_we    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    waddr_d   = awaddr;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // Out-of-range beats are accepted and dropped so the burst still completes.
                    mem_we  = in_range(waddr_q);
                    waddr_d = waddr_q + ADDR_WIDTH'(1);
                    if (wlast) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        init_done_q <= 1'b1;
        if (!init_done_q) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
            end
        end else if (mem_we) begin
            mem_q[waddr_q[IDX_W-1:0]] <= wdata;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = AXI_OKAY;

    assign rd_word_1 = mem_word(rd_idx_1);
    assign rd_word_2 = mem_word(rd_idx_2);

    axi_mem_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_1 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .araddr_i  (araddr),
        .arlen_i   (arlen),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rlast_o   (rlast),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .rd_idx_o  (rd_idx_1),
        .rd_word_i (rd_word_1)
    );

    axi_mem_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_2 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .araddr_i  (araddr_2),
        .arlen_i   (arlen_2),
        .arvalid_i (arvalid_2),
        .arready_o (arready_2),
        .rdata_o   (rdata_2),
        .rlast_o   (rlast_2),
        .rvalid_o  (rvalid_2),
        .rready_i  (rready_2),
        .rd_idx_o  (rd_idx_2),
        .rd_word_i (rd_word_2)
    );

endmodule

// File: tb/tb_axi_mem_slave_3ch.sv
// Directed bench for axi_mem_slave_3ch with a small, index-initialised memory.
module tb_axi_mem_slave_3ch;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MSZ = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr, araddr_2;
    logic [7:0]    arlen, arlen_2;
    logic          arvalid, arvalid_2;
    logic          arready, arready_2;
    logic [DW-1:0] rdata, rdata_2;
    logic          rlast, rlast_2;
    logic          rvalid, rvalid_2;
    logic          rready, rready_2;

    int total = 0;
    int bad   = 0;
    int k;

    axi_mem_slave_3ch #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (4),
        .MEM_SIZE    (MSZ),
        .INIT_OPTION (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .araddr_2  (araddr_2),
        .arlen_2   (arlen_2),
        .arvalid_2 (arvalid_2),
        .arready_2 (arready_2),
        .rdata_2   (rdata_2),
        .rlast_2   (rlast_2),
        .rvalid_2  (rvalid_2),
        .rready_2  (rready_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] p_rdata(input int p);
        return (p == 1) ? rdata : rdata_2;
    endfunction
    function automatic logic p_rvalid(input int p);
        return (p == 1) ? rvalid : rvalid_2;
    endfunction
    function automatic logic p_rlast(input int p);
        return (p == 1) ? rlast : rlast_2;
    endfunction
    function automatic logic p_arready(input int p);
        return (p == 1) ? arready : arready_2;
    endfunction

    task automatic ar_req(input int p, input logic [31:0] a, input logic [7:0] l);
        if (p == 1) begin
            araddr = a; arlen = l; arvalid = 1'b1;
        end else begin
            araddr_2 = a; arlen_2 = l; arvalid_2 = 1'b1;
        end
        tick();
        arvalid   = 1'b0;
        arvalid_2 = 1'b0;
    endtask

    // Full burst with rready held high; beat i must carry exp0+i.
    task automatic rd_burst(input int p, input logic [31:0] a, input int len, input logic [31:0] exp0);
        rready   = 1'b1;
        rready_2 = 1'b1;
        ar_req(p, a, 8'(len));
        chk("rd_arready_busy", p_arready(p), 1'b0);
        chk("rd_no_early_beat", p_rvalid(p), 1'b0);
        for (int i = 0; i <= len; i++) begin
            tick();
            chk("rd_rvalid", p_rvalid(p), 1'b1);
            chk("rd_rdata", p_rdata(p), exp0 + 32'(i));
            chk("rd_rlast", p_rlast(p), (i == len));
        end
        tick();
        chk("rd_rvalid_done", p_rvalid(p), 1'b0);
        chk("rd_arready_done", p_arready(p), 1'b1);
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [31:0] d0, input int n);
        awaddr  = a;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wr_awready_busy", awready, 1'b0);
        chk("wr_wready", wready, 1'b1);
        for (int i = 0; i < n; i++) begin
            wvalid = 1'b1;
            wdata  = d0 + 32'(i);
            wlast  = (i == n - 1);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("wr_bvalid", bvalid, 1'b1);
        chk("wr_bresp", bresp, 2'b00);
        chk("wr_wready_off", wready, 1'b0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("wr_bvalid_off", bvalid, 1'b0);
        chk("wr_awready_back", awready, 1'b1);
    endtask

    // AW and AR accepted on one edge: the single write beat commits on the edge that
    // presents read beat 0, so beat 0 sees old data and beat 1 sees any newly written word.
    task automatic collide(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                           input logic [31:0] e0, input logic [31:0] e1);
        rready  = 1'b1;
        awaddr  = wa; awvalid = 1'b1;
        araddr  = ra; arlen = 8'd1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        wvalid  = 1'b1; wdata = wd; wlast = 1'b1;
        chk("col_no_early_beat", rvalid, 1'b0);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("col_beat0", rdata, e0);
        chk("col_rlast0", rlast, 1'b0);
        chk("col_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("col_beat1", rdata, e1);
        chk("col_rlast1", rlast, 1'b1);
        tick();
        chk("col_rvalid_done", rvalid, 1'b0);
        chk("col_awready_back", awready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        araddr_2 = '0; arlen_2 = '0; arvalid_2 = 1'b0; rready_2 = 1'b0;
        repeat (3) tick();

        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_arready", arready, 1'b1);
        chk("rst_arready_2", arready_2, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rvalid_2", rvalid_2, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rlast_2", rlast_2, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rdata_2", rdata_2, 32'h0);
        rst_n = 1'b1;
        tick();

        // Port 1 burst over initialised words 10..17.
        rd_burst(1, 32'd10, 7, 32'd10);

        // Write 0xA0..0xA3 at 100, read back on port 2.
        wr_burst(32'd100, 32'hA0, 4);
        rd_burst(2, 32'd100, 3, 32'hA0);

        // Both ports in the same cycles.
        rready = 1'b1; rready_2 = 1'b1;
        araddr = 32'd0;    arlen   = 8'd7; arvalid   = 1'b1;
        araddr_2 = 32'd1280; arlen_2 = 8'd7; arvalid_2 = 1'b1;
        tick();
        arvalid = 1'b0; arvalid_2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("dual_rvalid", rvalid, 1'b1);
            chk("dual_rvalid_2", rvalid_2, 1'b1);
            chk("dual_rdata", rdata, 32'(i));
            chk("dual_rdata_2", rdata_2, 32'd1280 + 32'(i));
            chk("dual_rlast_2", rlast_2, (i == 7));
        end
        tick();
        chk("dual_done", rvalid | rvalid_2, 1'b0);

        // Port 1 with rready pattern 1,0,0,1,...: each word once, held while stalled.
        ar_req(1, 32'd20, 8'd3);
        tick();
        k = 0;
        for (int c = 0; c < 24 && k < 4; c++) begin
            chk("stall_rvalid", rvalid, 1'b1);
            chk("stall_rdata", rdata, 32'd20 + 32'(k));
            chk("stall_rlast", rlast, (k == 3));
            rready = (c % 3 == 0);
            tick();
            if (rready) k++;
        end
        chk("stall_beats", 32'(k), 32'd4);
        chk("stall_rvalid_done", rvalid, 1'b0);
        rready = 1'b1;

        // Concurrent write ahead of the second beat, then a same-edge collision.
        wr_burst(32'd200, 32'd5, 1);
        collide(32'd201, 32'h55, 32'd200, 32'd5, 32'h55);
        collide(32'd300, 32'h77, 32'd300, 32'd300, 32'd301);
        rd_burst(1, 32'd300, 0, 32'h77);

        // Out of range: write dropped (would alias word 7 if truncated), reads return 0.
        wr_burst(32'(MSZ) + 32'd7, 32'hDEAD, 1);
        rd_burst(1, 32'd7, 0, 32'd7);
        rd_burst(2, 32'(MSZ) + 32'd5, 0, 32'd0);

        // Reset in the middle of a port 2 burst.
        ar_req(2, 32'd40, 8'd7);
        tick();
        tick();
        chk("midrst_pre_rdata_2", rdata_2, 32'd41);
        rst_n = 1'b0;
        tick();
        chk("midrst_rvalid_2", rvalid_2, 1'b0);
        chk("midrst_arready_2", arready_2, 1'b1);
        chk("midrst_rdata_2", rdata_2, 32'd0);
        rst_n = 1'b1;
        tick();
        rd_burst(2, 32'd202, 0, 32'd202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
